mps_seq_fsm: RTL

Parametrised MPS system sequencer that replaces the fixed 3-contactor system FSM and its external op-on/op-off step FSMs. It runs contactor (MC) on/off sequences internally from programmable step patterns and per-step dwell timers, and checks MC feedback after each step. It latches multi-source interlocks until they are cleared, and issues a delayed post-mortem pulse. It sits between the register bank (commands, patterns, delays) and the MC drivers and PWM enable.

---
 rtl/mps_seq_fsm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mps_seq_fsm.sv
`default_nettype none
// ==== mps_seq_fsm : MPS sequencer - programmable MC on/off steps, fb check, interlock latch, PM pulse ====
// rev 1.0
module mps_seq_fsm #(
  parameter int              N_MC   = 3,
  parameter int              N_STEP = 4,
  parameter int              CNT_W  = 24,
  parameter int              N_INTL = 8,
  parameter logic [N_MC-1:0] MC_POL = 3'b100,
  parameter int              PM_DLY = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_op_on,
  input  logic                      i_op_off,
  input  logic                      i_run,
  input  logic                      i_ready,
  input  logic [N_INTL-1:0]         i_intl,
  input  logic                      i_intl_clr,
  input  logic [N_STEP*N_MC-1:0]    i_step_pat,
  input  logic [N_STEP*CNT_W-1:0]   i_step_dly,
  input  logic [N_MC-1:0]           i_mc_fb,
  input  logic                      i_fb_chk_en,
  output logic [2:0]                o_state,
  output logic [$clog2(N_STEP)-1:0] o_step,
  output logic [N_MC-1:0]           o_mc,
  output logic                      o_pwm_en,
  output logic                      o_pm,
  output logic [N_INTL-1:0]         o_intl_src,
  output logic                      o_fb_fault
);

  localparam int                STEP_W    = $clog2(N_STEP);
  localparam int                PM_W      = $clog2(PM_DLY + 2);
  localparam logic [PM_W-1:0]   PM_SAT    = PM_W'(PM_DLY + 1);
  localparam logic [PM_W-1:0]   PM_HIT    = PM_W'(PM_DLY);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEP - 1);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ON_SEQ  = 3'd1,
    READY   = 3'd2,
    RUN     = 3'd3,
    OFF_SEQ = 3'd4,
    INTL    = 3'd5
  } state_e;

  state_e              state, state_nxt;
  logic [STEP_W-1:0]   step, step_nxt, step_inc;
  logic [N_MC-1:0]     pat, pat_nxt;
  logic [N_MC-1:0]     mc;
  logic [CNT_W-1:0]    timer, timer_nxt;
  logic [N_INTL-1:0]   intl_src, intl_src_nxt;
  logic                fb_fault, fb_fault_nxt;
  logic [PM_W-1:0]     pm_cnt, pm_cnt_nxt;
  logic                pm;
  logic                expired, fb_bad;

  logic [N_MC-1:0]     on_pat    [N_STEP];
  logic [CNT_W-1:0]    on_dwell  [N_STEP];
  logic [N_MC-1:0]     off_pat   [N_STEP];
  logic [CNT_W-1:0]    off_dwell [N_STEP];

  // Off sequence walks the on patterns backwards, ending with all contactors open.
  for (genvar g = 0; g < N_STEP; g++) begin : g_step
    logic [CNT_W-1:0] dly;
    assign dly          = i_step_dly[g*CNT_W +: CNT_W];
    assign on_pat[g]    = i_step_pat[g*N_MC +: N_MC];
    assign on_dwell[g]  = (dly == '0) ? ONE : dly;
    assign off_dwell[g] = on_dwell[N_STEP-1-g];
    if (g < N_STEP - 1) begin : g_pat
      assign off_pat[g] = on_pat[N_STEP-2-g];
    end else begin : g_open
      assign off_pat[g] = '0;
    end
  end

  assign expired  = (timer == ONE);
  assign fb_bad   = i_fb_chk_en && (i_mc_fb != pat);
  assign step_inc = step + STEP_W'(1);

  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    pat_nxt      = pat;
    timer_nxt    = timer;
    intl_src_nxt = intl_src;
    fb_fault_nxt = fb_fault;
    if (|i_intl) begin
      state_nxt = INTL;
      step_nxt  = '0;
      pat_nxt   = '0;
      timer_nxt = '0;
      if (state == INTL) begin
        intl_src_nxt = intl_src | i_intl;
      end else begin
        intl_src_nxt = i_intl;
        fb_fault_nxt = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (i_op_on) begin
            state_nxt = ON_SEQ;
            step_nxt  = '0;
            pat_nxt   = on_pat[0];
            timer_nxt = on_dwell[0];
          end
        end
        ON_SEQ, OFF_SEQ: begin
          if (expired && fb_bad) begin
            state_nxt    = INTL;
            step_nxt     = '0;
            pat_nxt      = '0;
            timer_nxt    = '0;
            intl_src_nxt = '0;
            fb_fault_nxt = 1'b1;
          end else if (state == ON_SEQ && i_op_off) begin
            state_nxt = OFF_SEQ;
            step_nxt  = '0;
            pat_nxt   = off_pat[0];
            timer_nxt = off_dwell[0];
          end else if (!expired) begin
            timer_nxt = timer - ONE;
          end else if (step == LAST_STEP) begin
            if (state == ON_SEQ) state_nxt = READY;
            else                 state_nxt = IDLE;
            step_nxt  = '0;
            timer_nxt = '0;
          end else begin
            step_nxt = step_inc;
            if (state == ON_SEQ) begin
              pat_nxt   = on_pat[step_inc];
              timer_nxt = on_dwell[step_inc];
            end else begin
              pat_nxt   = off_pat[step_inc];
              timer_nxt = off_dwell[step_inc];
            end
          end
        end
        READY: begin
          if (i_run) begin
            state_nxt = RUN;
          end else if (i_op_off) begin
            state_nxt = OFF_SEQ;
            step_nxt  = '0;
            pat_nxt   = off_pat[0];
            timer_nxt = off_dwell[0];
          end
        end
        RUN: begin
          if (i_ready) state_nxt = READY;
        end
        INTL: begin
          if (i_intl_clr) begin
            state_nxt    = IDLE;
            intl_src_nxt = '0;
            fb_fault_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          step_nxt  = '0;
          pat_nxt   = '0;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Counter parks at PM_SAT outside INTL so a pulse can only follow a fresh entry.
  always_comb begin
    pm_cnt_nxt = pm_cnt;
    if (state_nxt != INTL)   pm_cnt_nxt = PM_SAT;
    else if (state != INTL)  pm_cnt_nxt = '0;
    else if (pm_cnt != PM_SAT) pm_cnt_nxt = pm_cnt + PM_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      step     <= '0;
      pat      <= '0;
      mc       <= MC_POL;
      timer    <= '0;
      intl_src <= '0;
      fb_fault <= 1'b0;
      pm_cnt   <= PM_SAT;
      pm       <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      pat      <= pat_nxt;
      mc       <= pat_nxt ^ MC_POL;
      timer    <= timer_nxt;
      intl_src <= intl_src_nxt;
      fb_fault <= fb_fault_nxt;
      pm_cnt   <= pm_cnt_nxt;
      pm       <= (pm_cnt_nxt == PM_HIT);
    end
  end

  assign o_state    = state;
  assign o_step     = step;
  assign o_mc       = mc;
  assign o_pwm_en   = (state == RUN);
  assign o_pm       = pm;
  assign o_intl_src = intl_src;
  assign o_fb_fault = fb_fault;

endmodule
`default_nettype wire
